uart_rx: RTL and testbench

- Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter.
- Samples the serial line with a 16x oversampling enable, detects the start bit, and shifts in 8 data bits LSB first.
- Checks the optional parity bit and the stop bit.
- Presents the received byte, a one-cycle done strobe and error flags to the host logic.
- Frame format: 1 start (0), 8 data, optional parity, 1 stop (1).

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 8N1 or 8 data + odd/even parity; rx_done pulses at mid stop bit,
// roughly 2 clk synchronizer delay after the line. No backpressure: the host must take data_out on rx_done.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_active,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           par_type;
  logic                 par_bad;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_s_d;

  logic fall_edge;
  logic half_hit;
  logic full_hit;
  logic par_en;
  logic par_exp;

  assign fall_edge = rx_s_d & ~rx_s;
  assign half_hit  = sample_tick && (tick_cnt == TICK_HALF);
  assign full_hit  = sample_tick && (tick_cnt == TICK_LAST);
  assign par_en    = (par_type == 2'b01) || (par_type == 2'b10);
  // Even parity expects the XOR of the data bits; odd parity expects its inverse.
  assign par_exp   = (^shift_reg) ^ (par_type == 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_type   <= 2'b00;
      par_bad    <= 1'b0;
      data_out   <= '0;
      rx_active  <= 1'b0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          // A held-low line (break) never retriggers: only a real 1->0 edge starts a frame.
          if (fall_edge) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (half_hit) begin
            if (!rx_s) begin
              state     <= DATA;
              rx_active <= 1'b1;
              par_type  <= parity_type;
              par_bad   <= 1'b0;
              tick_cnt  <= '0;
              bit_cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        DATA: begin
          if (full_hit) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            tick_cnt  <= '0;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= par_en ? PARITY : STOP;
            end
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (full_hit) begin
            par_bad  <= (rx_s != par_exp);
            tick_cnt <= '0;
            state    <= STOP;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOP: begin
          if (full_hit) begin
            data_out   <= shift_reg;
            parity_err <= par_en & par_bad;
            frame_err  <= ~rx_s;
            rx_done    <= 1'b1;
            rx_active  <= 1'b0;
            tick_cnt   <= '0;
            state      <= IDLE;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          tick_cnt  <= '0;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: sample_tick every 4 clk, so one bit period is 64 clk.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       sample_tick = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  int         done_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  int         active_len = 0;
  logic       act_prev = 1'b0;
  logic       saw_active = 1'b0;
  logic [1:0] tick_div = 2'd0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .sample_tick(sample_tick),
    .parity_type(parity_type),
    .data_out   (data_out),
    .rx_active  (rx_active),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div    <= tick_div + 2'd1;
    sample_tick <= (tick_div == 2'd3);
  end

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt  = done_cnt + 1;
      prev_data = last_data;
      last_data = data_out;
      last_perr = parity_err;
      last_ferr = frame_err;
    end
    if (rx_active) begin
      if (!act_prev) active_len = 0;
      active_len = active_len + 1;
      saw_active = 1'b1;
    end
    act_prev = rx_active;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] d,
                             input logic perr, input logic ferr);
    check({tag, " done"}, done_cnt, base + 1);
    check({tag, " data"}, last_data, d);
    check({tag, " parity_err"}, last_perr, perr);
    check({tag, " frame_err"}, last_ferr, ferr);
  endtask

  initial begin
    int base;
    @(negedge clk);
    check("reset data_out", data_out, 0);
    check("reset rx_active", rx_active, 0);
    check("reset rx_done", rx_done, 0);
    check("reset parity_err", parity_err, 0);
    check("reset frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);

    // Parity none, 0xA5
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("none A5", base, 8'hA5, 1'b0, 1'b0);
    check("none A5 active_len", active_len, 9 * BIT_CLKS);

    // Even parity
    parity_type = 2'b10;
    base = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("even 3C p0", base, 8'h3C, 1'b0, 1'b0);
    base = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check_frame("even 3C p1", base, 8'h3C, 1'b1, 1'b0);

    // Odd parity; parity_type change mid-frame must be ignored
    parity_type = 2'b01;
    base = done_cnt;
    fork
      send_frame(8'h01, 1'b1, 1'b0, 1'b1);
      begin
        repeat (3 * BIT_CLKS) @(negedge clk);
        parity_type = 2'b00;
      end
    join
    idle_bits(1);
    check_frame("odd 01 p0", base, 8'h01, 1'b0, 1'b0);
    parity_type = 2'b01;
    base = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("odd 00 p0", base, 8'h00, 1'b1, 1'b0);

    // Glitch rejection: 4 ticks low
    parity_type = 2'b00;
    saw_active = 1'b0;
    base = done_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    idle_bits(2);
    check("glitch rx_active", saw_active, 0);
    check("glitch rx_done", done_cnt, base);
    base = done_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("after glitch 5A", base, 8'h5A, 1'b0, 1'b0);

    // Break: stop bit 0, line stays low
    base = done_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_frame("break FF", base, 8'hFF, 1'b0, 1'b1);
    idle_bits(1);
    check("break no retrigger", done_cnt, base + 1);
    base = done_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("after break 12", base, 8'h12, 1'b0, 1'b0);

    // Reset after 4 data bits of 0x77
    base = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h77 >> i));
    check("midframe rx_active before rst", rx_active, 1);
    rst = 1'b1;
    #1;
    check("midrst data_out", data_out, 0);
    check("midrst rx_active", rx_active, 0);
    check("midrst parity_err", parity_err, 0);
    check("midrst frame_err", frame_err, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle_bits(6);
    check("midrst no rx_done", done_cnt, base);

    // Back-to-back 0x81 frames
    base = done_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    check("b2b done count", done_cnt, base + 2);
    check("b2b first data", prev_data, 8'h81);
    check("b2b second data", last_data, 8'h81);
    check("b2b frame_err", last_ferr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
